// File: rtl/date_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : date_display_driver
// Description : Shows the calendar date on a 4-digit multiplexed 7-segment
//               display. Binary day/month/year go through a sequential
//               double-dabble converter. Two pages, DD.MM and 20YY,
//               alternate on a seconds count taken from tick_1Hz.
// Revision    : 1.0 - initial release
// ============================================================================
module date_display_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int PAGE_SECONDS = 3
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       tick_1Hz,
    input  logic [7:0] day,
    input  logic [7:0] month,
    input  logic [7:0] year,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       page
);

    localparam int DIV_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int PCNT_W = (PAGE_SECONDS > 1) ? $clog2(PAGE_SECONDS + 1) : 1;

    localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [PCNT_W-1:0] c_pcnt_last = PCNT_W'(PAGE_SECONDS - 1);

    // Field slots inside the packed field arrays
    localparam int c_f_day   = 0;
    localparam int c_f_month = 1;
    localparam int c_f_year  = 2;

    // Conversion FSM states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Display symbol used for a field that does not fit in two digits
    localparam logic [3:0] c_sym_dash = 4'd10;

    // ------------------------------------------------------------------------
    // Conversion path state
    // ------------------------------------------------------------------------
    logic [2:0][7:0]  w_in;
    logic [2:0][7:0]  r_snap;
    logic [2:0][7:0]  r_src;
    logic [2:0][11:0] r_bcd;
    logic [2:0][11:0] w_bcd_next;
    logic [2:0][3:0]  r_disp_tens;
    logic [2:0][3:0]  r_disp_ones;
    logic [2:0]       r_disp_oor;
    logic [1:0]       r_state;
    logic             r_pending;
    logic [2:0]       r_bitcnt;

    // ------------------------------------------------------------------------
    // Scan and page state
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_idx;
    logic              r_slot_page;
    logic [1:0]        r_sync;
    logic              r_tick_d;
    logic              w_tick_rise;
    logic [PCNT_W-1:0] r_pcnt;
    logic              r_page;
    logic              w_page_next;
    logic              w_div_wrap;
    logic [3:0]        w_sym;
    logic              w_dp;

    assign w_in = {year, month, day};

    // One double-dabble step: add 3 to every nibble >= 5, then shift left
    function automatic logic [11:0] dd_step(input logic [11:0] bcd_in, input logic bit_in);
        logic [11:0] adj;
        adj = bcd_in;
        for (int n = 0; n < 3; n++) begin
            if (adj[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
            end
        end
        return {adj[10:0], bit_in};
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for a symbol; anything above 9 is a dash
    function automatic logic [6:0] seg_code(input logic [3:0] sym);
        logic [6:0] code;
        case (sym)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b0111111;
        endcase
        return code;
    endfunction

    // All three fields shift in parallel, MSB of the latched source first
    generate
        for (genvar f = 0; f < 3; f++) begin : g_dd
            assign w_bcd_next[f] = dd_step(r_bcd[f], r_src[f][3'd7 - r_bitcnt]);
        end
    endgenerate

    // Snapshot inputs and run the IDLE/LOAD/SHIFT/DONE conversion sequence
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_snap      <= '0;
            r_src       <= '0;
            r_bcd       <= '0;
            r_disp_tens <= '0;
            r_disp_ones <= '0;
            r_disp_oor  <= '0;
            r_state     <= S_IDLE;
            r_pending   <= 1'b1;
            r_bitcnt    <= 3'd0;
        end else begin
            r_snap <= w_in;
            case (r_state)
                S_IDLE: begin
                    if (r_pending || (r_snap != r_src)) begin
                        r_state   <= S_LOAD;
                        r_pending <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_src    <= r_snap;
                    r_bcd    <= '0;
                    r_bitcnt <= 3'd0;
                    r_state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_next;
                    if (r_bitcnt == 3'd7) begin
                        r_state <= S_DONE;
                    end else begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
                S_DONE: begin
                    // Commit all fields together so a half-updated date is never shown
                    for (int f = 0; f < 3; f++) begin
                        r_disp_tens[f] <= r_bcd[f][7:4];
                        r_disp_ones[f] <= r_bcd[f][3:0];
                        r_disp_oor[f]  <= |r_bcd[f][11:8];
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Synchronise tick_1Hz and keep the previous synchronised level for edge detect
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_sync   <= 2'b00;
            r_tick_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], tick_1Hz};
            r_tick_d <= r_sync[1];
        end
    end

    assign w_tick_rise = r_sync[1] & ~r_tick_d;
    assign w_page_next = (w_tick_rise && (r_pcnt == c_pcnt_last)) ? ~r_page : r_page;
    assign w_div_wrap  = (r_div == c_div_last);

    // Count seconds and flip the page once PAGE_SECONDS ticks have been seen
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_pcnt <= '0;
            r_page <= 1'b0;
        end else if (w_tick_rise) begin
            if (r_pcnt == c_pcnt_last) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PCNT_W'(1);
            end
            r_page <= w_page_next;
        end
    end

    // Refresh divider and digit index; the page is resampled only at slot starts
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_div       <= '0;
            r_idx       <= 2'd0;
            r_slot_page <= 1'b0;
        end else if (w_div_wrap) begin
            r_div       <= '0;
            r_idx       <= r_idx + 2'd1;
            // Uses the next page value so a toggle on this same edge is honoured
            r_slot_page <= w_page_next;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Pick the symbol and decimal point for the digit currently being scanned
    always_comb begin
        w_sym = 4'd0;
        w_dp  = 1'b1;
        if (!r_slot_page) begin
            case (r_idx)
                2'd0: w_sym = r_disp_oor[c_f_day]   ? c_sym_dash : r_disp_tens[c_f_day];
                2'd1: begin
                    w_sym = r_disp_oor[c_f_day] ? c_sym_dash : r_disp_ones[c_f_day];
                    w_dp  = 1'b0;
                end
                2'd2: w_sym = r_disp_oor[c_f_month] ? c_sym_dash : r_disp_tens[c_f_month];
                2'd3: w_sym = r_disp_oor[c_f_month] ? c_sym_dash : r_disp_ones[c_f_month];
                default: w_sym = 4'd0;
            endcase
        end else begin
            case (r_idx)
                2'd0: w_sym = 4'd2;
                2'd1: w_sym = 4'd0;
                2'd2: w_sym = r_disp_oor[c_f_year] ? c_sym_dash : r_disp_tens[c_f_year];
                2'd3: w_sym = r_disp_oor[c_f_year] ? c_sym_dash : r_disp_ones[c_f_year];
                default: w_sym = 4'd0;
            endcase
        end
    end

    // Register the display drive; blank turns everything off without stopping the scan
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else if (blank) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b1000 >> r_idx);
            seg <= seg_code(w_sym);
            dp  <= w_dp;
        end
    end

    assign page = r_page;

endmodule
`default_nettype wire

// File: doc/date_display_driver.md
Name: date_display_driver

Overview:
- Reader side of the calendar's date outputs. Consumes binary day/month/year and drives a 4-digit multiplexed 7-segment display.
- Converts binary to BCD with a sequential double-dabble FSM.
- Scans digits at a fixed refresh rate.
- Alternates between two pages, DD.MM and 20YY, every PAGE_SECONDS seconds of tick_1Hz.

Parameters:
REFRESH_DIV, 100000, clk_100MHz cycles per digit slot (1 ms at 100 MHz); minimum 2
PAGE_SECONDS, 3, tick_1Hz rising edges per page before toggling; minimum 1

Ports:
clk_100MHz  input  1  system clock; all state on rising edge
reset  input  1  reset, asynchronous, active-high
tick_1Hz  input  1  1 Hz pulse/level from clock module; asynchronous to clk, synchronised internally
day  input  8  binary day, valid 0..99
month  input  8  binary month, valid 0..99
year  input  8  binary year, valid 0..99
blank  input  1  1 = all anodes off; scanning and conversion continue
an  output  4  anode enables, active-low; an[3] leftmost digit
seg  output  7  {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
page  output  1  0 = DD.MM, 1 = 20YY

Behaviour:
- Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1, page=0.
  - Digit index 0, refresh divider 0, page counter 0.
  - All BCD display registers 0; input snapshot registers 0.
  - FSM state IDLE with pending=1, so a conversion starts immediately after reset release.
- Input capture: day/month/year registered every cycle into snapshot registers.
- Conversion FSM states:
  - IDLE: if pending, or snapshot != last-converted source, go to LOAD and clear pending.
  - LOAD: one cycle. Latch snapshot as source; clear three 12-bit shift registers.
  - SHIFT: 8 cycles, one bit per cycle MSB-first. For all three fields in parallel: add 3 to any BCD nibble >=5, then shift left.
  - DONE: one cycle. Commit BCD tens/ones for all fields atomically; return to IDLE.
- Latency: input change captured at edge E gives IDLE->LOAD at E+1, SHIFT at E+2..E+9, DONE at E+10; new digits are displayed from E+11.
- Mid-conversion input change: the current conversion completes with the old source; IDLE then detects the mismatch and reconverts. No partial values are ever displayed.
- Out-of-range value (>99, hundreds nibble != 0): that field displays two dashes (seg=7'b0111111).
- Reset mid-conversion: abort immediately; all state returns to reset values.
- Refresh divider:
  - Counts 0..REFRESH_DIV-1.
  - On terminal count, wraps to 0 and advances the digit index 0->1->2->3->0.
  - Index k drives an[3-k] low, all other anodes high; an/seg/dp are registered, so they update 1 cycle after the index changes.
- Page 0 order, left to right: day tens, day ones, month tens, month ones. dp is low only on the day-ones digit. Leading zeros are shown.
- Page 1 order, left to right: '2', '0', year tens, year ones. dp is high on all digits.
- Segment codes, active-low {g..a}:
  - Digits 0-4: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - Digits 5-9: 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Dash: 0111111.
- Blank: forces an=4'b1111 and seg=7'b1111111 (active-low, so all segments off) and dp=1 on the next cycle. The divider, digit index, page and conversion all keep running.
- Page timer:
  - tick_1Hz passes through a 2-FF synchroniser plus rising-edge detect, giving a one-cycle pulse.
  - Each pulse increments the page counter. At PAGE_SECONDS pulses, page toggles and the counter clears, in the same cycle.
  - Page change takes effect at the next digit slot; a slot is never split.
- Simultaneous divider terminal count and page toggle: the new index uses the new page.

Test Plan:
- Reset and defaults (REFRESH_DIV=4, PAGE_SECONDS=3):
  - Assert reset mid-scan → an=1111, seg=1111111, dp=1, page=0 asynchronously.
  - Release with day=1, month=9, year=1 → within 12 cycles the scan shows an=0111 seg=1000000; an=1011 seg=1111001 dp=0; an=1101 seg=1000000; an=1110 seg=0010000.
- Conversion latency: change day 1→31 at edge E → digit codes 0110000/1111001 first appear in slots after E+11; old "01" is shown up to E+10, with no mixed values.
- Page toggle: 3 tick_1Hz rising edges → page=1 and digits "2","0","0","1" with dp=1 throughout; 3 more edges → page=0.
- Out of range and blank:
  - month=150 → month digits both 0111111 while day digits are unaffected.
  - blank=1 → an=1111 next cycle; blank=0 resumes the scan at the current index.
- Reset mid-conversion: change year during SHIFT, then pulse reset → BCD 00, page 0; after release, a fresh conversion of the current inputs completes.
